// File: rtl/cg_iteration_sequencer.sv
// -----------------------------------------------------------------------------
// cg_iteration_sequencer
//
// Phase controller for the conjugate-gradient ALU datapath. Each iteration
// walks through: A*p, p.Ap, alpha divide, x/r update sweep, r.r, beta divide,
// and the p update sweep. The solve ends on convergence or at the iteration
// limit.
//
// Ports:
//   clk, reset          clock and synchronous active-high reset
//   start               one-cycle pulse, begins a solve (from IDLE or DONE)
//   total               words per vector (sweep length), captured at start
//   max_iter            iteration limit, 0 behaves as 1
//   mXv_finish, vXv1_finish, vXv2_finish, div_done
//                       completion pulses from the datapath units
//   converged           residual below tolerance, looked at with vXv2_finish
//   reset_mXv1, reset_vXv1, reset_vXv2
//                       one-cycle restart pulses to the datapath units
//   div_start, div_sel  divider kick-off and operand select (0 alpha, 1 beta)
//   mem_address         sweep address
//   memory*_we          vector memory write enables
//   iteration           completed iterations (saturating)
//   busy, finish_all    activity and completion flags
//
// All outputs are decoded from registered state only (Moore machine).
// -----------------------------------------------------------------------------
module cg_iteration_sequencer #(
  parameter int memories_address_width = 32,
  parameter int iteration_width        = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [31:0]                       total,
  input  logic [iteration_width-1:0]        max_iter,
  input  logic                              mXv_finish,
  input  logic                              vXv1_finish,
  input  logic                              vXv2_finish,
  input  logic                              div_done,
  input  logic                              converged,
  output logic                              reset_mXv1,
  output logic                              reset_vXv1,
  output logic                              reset_vXv2,
  output logic                              div_start,
  output logic                              div_sel,
  output logic [memories_address_width-1:0] mem_address,
  output logic                              memoryX_we,
  output logic                              memoryR_we,
  output logic                              memoryRprev_we,
  output logic                              memoryP_we,
  output logic [iteration_width-1:0]        iteration,
  output logic                              busy,
  output logic                              finish_all
);

  typedef enum logic [3:0] {
    IDLE, MXV_RST, MXV_RUN, VXV1_RST, VXV1_RUN, ALPHA_GO, ALPHA_WAIT,
    UPD_XR, VXV2_RST, VXV2_RUN, BETA_GO, BETA_WAIT, UPD_P, DONE
  } state_t;

  // Counter is at least as wide as total so the last-word compare never truncates.
  localparam int CW = (memories_address_width > 32) ? memories_address_width : 32;

  state_t                     state_reg, state_next;
  logic [CW-1:0]              addr_reg, addr_next;
  logic [iteration_width-1:0] iter_reg, iter_next;
  logic                       div_sel_reg, div_sel_next;
  logic [31:0]                total_reg, total_next;

  logic                       total_zero;
  logic                       sweep_last;
  logic [iteration_width-1:0] iter_inc;
  logic [iteration_width-1:0] max_eff;
  logic                       limit_hit;

  // total is latched at start so the write enables never depend on a live input.
  assign total_zero = (total_reg == 32'd0);
  assign sweep_last = total_zero || (addr_reg == (CW'(total_reg) - CW'(1)));
  assign iter_inc   = (&iter_reg) ? iter_reg : iter_reg + iteration_width'(1);
  assign max_eff    = (max_iter == '0) ? iteration_width'(1) : max_iter;
  // One extra bit so a saturated counter still compares as "limit reached".
  assign limit_hit  = (({1'b0, iter_reg} + (iteration_width+1)'(1)) >= {1'b0, max_eff});

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      addr_reg    <= '0;
      iter_reg    <= '0;
      div_sel_reg <= 1'b0;
      total_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      iter_reg    <= iter_next;
      div_sel_reg <= div_sel_next;
      total_reg   <= total_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    iter_next    = iter_reg;
    div_sel_next = div_sel_reg;
    total_next   = total_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next = MXV_RST;
          iter_next  = '0;
          total_next = total;
        end
      end
      MXV_RST:  state_next = MXV_RUN;
      MXV_RUN:  if (mXv_finish) state_next = VXV1_RST;
      VXV1_RST: state_next = VXV1_RUN;
      VXV1_RUN: begin
        if (vXv1_finish) begin
          state_next   = ALPHA_GO;
          div_sel_next = 1'b0;
        end
      end
      ALPHA_GO:   state_next = ALPHA_WAIT;
      ALPHA_WAIT: if (div_done) state_next = UPD_XR;
      UPD_XR: begin
        if (sweep_last) begin
          state_next = VXV2_RST;
          addr_next  = '0;
        end else begin
          addr_next = addr_reg + CW'(1);
        end
      end
      VXV2_RST: state_next = VXV2_RUN;
      VXV2_RUN: begin
        if (vXv2_finish) begin
          if (converged || limit_hit) begin
            state_next = DONE;
            iter_next  = iter_inc;
          end else begin
            state_next   = BETA_GO;
            div_sel_next = 1'b1;
          end
        end
      end
      BETA_GO:   state_next = BETA_WAIT;
      BETA_WAIT: if (div_done) state_next = UPD_P;
      UPD_P: begin
        if (sweep_last) begin
          state_next = MXV_RST;
          addr_next  = '0;
          iter_next  = iter_inc;
        end else begin
          addr_next = addr_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign reset_mXv1     = (state_reg == MXV_RST);
  assign reset_vXv1     = (state_reg == VXV1_RST);
  assign reset_vXv2     = (state_reg == VXV2_RST);
  assign div_start      = (state_reg == ALPHA_GO) || (state_reg == BETA_GO);
  assign div_sel        = div_sel_reg;
  // addr_reg is cleared at the end of each sweep, so it reads 0 elsewhere.
  assign mem_address    = addr_reg[memories_address_width-1:0];
  assign memoryX_we     = (state_reg == UPD_XR) && !total_zero;
  assign memoryR_we     = (state_reg == UPD_XR) && !total_zero;
  assign memoryRprev_we = (state_reg == UPD_XR) && !total_zero;
  assign memoryP_we     = (state_reg == UPD_P) && !total_zero;
  assign iteration      = iter_reg;
  assign busy           = (state_reg != IDLE) && (state_reg != DONE);
  assign finish_all     = (state_reg == DONE);

endmodule
